// File: rtl/tt_scan_pkg.sv
// Shared types and constants for the truth-table scanner.
package tt_scan_pkg;

    localparam int IDX_W = 4;
    localparam int N_VEC = 16;
    localparam int CNT_W = 5;

    // Golden table of the current POS function: ones at 2,3,4,5,10,11,13,15.
    localparam logic [15:0] TT_EX01B = 16'hAC3C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    // Required function output for a given input code.
    function automatic logic golden_bit(input logic [15:0] golden, input logic [IDX_W-1:0] idx);
        return golden[idx];
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each input code is held.
module tt_settle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Count down while enabled; a load always wins so a new vector restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps the 4-input function through all 16 codes, captures its truth
// table and compares it against a golden table.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = TT_EX01B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [IDX_W-1:0] abcd_out,
    input  logic             s_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      table_out,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fail_valid,
    output logic [IDX_W-1:0] first_fail_idx
);

    // The timer is loaded with SETTLE_CYCLES-1 and SETTLE exits on zero,
    // so SETTLE lasts exactly SETTLE_CYCLES cycles.
    localparam int               TMR_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_VEC - 1);

    scan_state_t      state_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] abcd_r;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic [15:0]      tt_r;
    logic [CNT_W-1:0] cnt_r;
    logic             fail_valid_r;
    logic [IDX_W-1:0] first_fail_r;

    logic             miss_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             timer_load_s;
    logic             timer_en_s;
    logic             timer_zero_s;

    // Compare the current sample against the golden bit and decode timer controls.
    always_comb begin
        miss_s       = (s_in != golden_bit(EXPECTED, idx_r));
        cnt_next_s   = cnt_r + CNT_W'(miss_s);
        timer_load_s = 1'b0;
        timer_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                timer_load_s = start;
            end
            SETTLE: begin
                timer_en_s = 1'b1;
            end
            SAMPLE: begin
                timer_load_s = (idx_r != IDX_LAST);
            end
            DONE: begin
                timer_load_s = 1'b0;
            end
            default: begin
                timer_load_s = 1'b0;
                timer_en_s   = 1'b0;
            end
        endcase
    end

    tt_settle_timer #(
        .W (TMR_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (TMR_LOAD),
        .en       (timer_en_s),
        .zero     (timer_zero_s)
    );

    // Scan sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            idx_r        <= '0;
            abcd_r       <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            tt_r         <= 16'h0000;
            cnt_r        <= '0;
            fail_valid_r <= 1'b0;
            first_fail_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r      <= SETTLE;
                        idx_r        <= '0;
                        abcd_r       <= '0;
                        busy_r       <= 1'b1;
                        pass_r       <= 1'b0;
                        tt_r         <= 16'h0000;
                        cnt_r        <= '0;
                        fail_valid_r <= 1'b0;
                        first_fail_r <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETTLE: begin
                    if (timer_zero_s) begin
                        state_r <= SAMPLE;
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                SAMPLE: begin
                    tt_r[idx_r] <= s_in;
                    if (miss_s) begin
                        cnt_r <= cnt_next_s;
                        if (!fail_valid_r) begin
                            fail_valid_r <= 1'b1;
                            first_fail_r <= idx_r;
                        end else begin
                            first_fail_r <= first_fail_r;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (idx_r == IDX_LAST) begin
                        // Pass must include this final sample, so use the next count.
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        pass_r  <= (cnt_next_s == '0);
                    end else begin
                        // Inputs only move here, leaving them stable through SETTLE.
                        state_r <= SETTLE;
                        idx_r   <= idx_r + IDX_W'(1);
                        abcd_r  <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign abcd_out       = abcd_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign table_out      = tt_r;
    assign mismatch_cnt   = cnt_r;
    assign fail_valid     = fail_valid_r;
    assign first_fail_idx = first_fail_r;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench for truth_table_scanner with a scoreboard of expected results.
module tb_truth_table_scanner;

    localparam int SETTLE = 2;
    localparam int LAT    = 16 * (SETTLE + 1) + 1;

    typedef struct packed {
        logic [15:0] tt;
        logic [4:0]  cnt;
        logic        fv;
        logic [3:0]  ffi;
        logic        ps;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        s_in;
    logic [3:0]  abcd_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  mismatch_cnt;
    logic        fail_valid;
    logic [3:0]  first_fail_idx;

    logic [15:0] gold;
    int          mode;
    int          checks;
    int          errors;
    res_t        exp_q[$];

    truth_table_scanner #(
        .SETTLE_CYCLES (SETTLE),
        .EXPECTED      (16'hAC3C)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abcd_out       (abcd_out),
        .s_in           (s_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .table_out      (table_out),
        .mismatch_cnt   (mismatch_cnt),
        .fail_valid     (fail_valid),
        .first_fail_idx (first_fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function block stand-in: 0 real, 1 tied low, 2 tied high, 3 inverted.
    always_comb begin
        case (mode)
            1:       s_in = 1'b0;
            2:       s_in = 1'b1;
            3:       s_in = ~gold[abcd_out];
            default: s_in = gold[abcd_out];
        endcase
    end

    function automatic res_t model(input int m);
        res_t r;
        logic s;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            case (m)
                1:       s = 1'b0;
                2:       s = 1'b1;
                3:       s = ~gold[i];
                default: s = gold[i];
            endcase
            r.tt[i] = s;
            if (s != gold[i]) begin
                r.cnt = r.cnt + 5'd1;
                if (!r.fv) begin
                    r.fv  = 1'b1;
                    r.ffi = 4'(i);
                end
            end
        end
        r.ps = (r.cnt == 5'd0);
        return r;
    endfunction

    function automatic res_t observed();
        return {table_out, mismatch_cnt, fail_valid, first_fail_idx, pass};
    endfunction

    // Push the expected result, pulse (or hold) start, and wait for done.
    task automatic run_scan(input int m, input bit hold, output int lat, output bit got);
        mode = m;
        exp_q.push_back(model(m));
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        got = 1'b0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) start = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({abcd_out, busy, done, pass, table_out, mismatch_cnt, fail_valid, first_fail_idx} !== 33'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0",
                     {abcd_out, busy, done, pass, table_out, mismatch_cnt, fail_valid, first_fail_idx});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_golden();
        int lat;
        bit got;
        res_t e;
        run_scan(0, 1'b0, lat, got);
        checks++;
        if (!got || lat !== LAT) begin
            errors++;
            $display("FAIL golden_latency: got=%0b lat=%0d expected %0d", got, lat, LAT);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL golden_busy_in_done: busy=%b expected 1", busy);
        end
        e = exp_q.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL golden_result: got %h expected %h", observed(), e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || observed() !== e) begin
            errors++;
            $display("FAIL golden_after_done: done=%b busy=%b res=%h expected 0 0 %h", done, busy, observed(), e);
        end
    endtask

    task automatic test_fault_patterns();
        int lat;
        bit got;
        res_t e;
        for (int m = 1; m <= 3; m++) begin
            run_scan(m, 1'b0, lat, got);
            e = exp_q.pop_front();
            checks++;
            if (!got || lat !== LAT) begin
                errors++;
                $display("FAIL pattern%0d_latency: got=%0b lat=%0d expected %0d", m, got, lat, LAT);
            end
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL pattern%0d_result: got %h expected %h", m, observed(), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midscan();
        int lat;
        bit got;
        bit found;
        int pulses;
        res_t e;
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (abcd_out == 4'd7) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midscan_reach_idx7: abcd_out=%0d expected 7", abcd_out);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({abcd_out, busy, done, pass, table_out, mismatch_cnt, fail_valid, first_fail_idx} !== 33'd0) begin
            errors++;
            $display("FAIL midscan_reset_values: got %h expected 0",
                     {abcd_out, busy, done, pass, table_out, mismatch_cnt, fail_valid, first_fail_idx});
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midscan_no_done: pulses=%0d expected 0", pulses);
        end
        run_scan(0, 1'b0, lat, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat !== LAT || observed() !== e) begin
            errors++;
            $display("FAIL midscan_rescan: got=%0b lat=%0d res=%h expected lat %0d res %h", got, lat, observed(), LAT, e);
        end
        @(negedge clk);
    endtask

    task automatic test_start_handling();
        int lat;
        bit got;
        res_t e;
        // start held through the scan and into the DONE cycle.
        run_scan(0, 1'b1, lat, got);
        e = exp_q.pop_front();
        checks++;
        if (!got || lat !== LAT || observed() !== e) begin
            errors++;
            $display("FAIL held_start_scan: got=%0b lat=%0d res=%h expected lat %0d res %h", got, lat, observed(), LAT, e);
        end
        // start was high at the DONE edge: must not restart.
        exp_q.push_back(model(0));
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL done_cycle_start_ignored: busy=%b done=%b expected 0 0", busy, done);
        end
        // start still high in IDLE: accepted on this edge.
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || observed() !== '0) begin
            errors++;
            $display("FAIL restart_clears: busy=%b res=%h expected 1 0", busy, observed());
        end
        got = 1'b0;
        lat = 0;
        for (int c = 2; c <= 200 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                lat = c;
            end
        end
        e = exp_q.pop_front();
        checks++;
        if (!got || lat !== LAT || observed() !== e) begin
            errors++;
            $display("FAIL restart_result: got=%0b lat=%0d res=%h expected lat %0d res %h", got, lat, observed(), LAT, e);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    initial begin
        gold   = 16'hAC3C;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 0;
        test_reset();
        test_golden();
        test_fault_patterns();
        test_reset_midscan();
        test_start_handling();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
